// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed byte frame,
// writes little-endian 32-bit words into the instruction store and validates a trailing checksum.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  // 8-bit modular checksum accumulation
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    csum_add = sum + b;
  endfunction

  function automatic logic rx_state(input logic [2:0] st);
    case (st)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: rx_state = 1'b1;
      default:                            rx_state = 1'b0;
    endcase
  endfunction

  function automatic logic busy_state(input logic [2:0] st);
    case (st)
      S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM: busy_state = 1'b1;
      default:                                     busy_state = 1'b0;
    endcase
  endfunction

  logic [2:0]        state_r, state_nxt_s;
  logic [7:0]        len_lo_r, len_lo_nxt_s;
  logic [15:0]       len_r, len_nxt_s;
  logic [7:0]        word_idx_r, word_idx_nxt_s;
  logic [1:0]        byte_idx_r, byte_idx_nxt_s;
  logic [31:0]       shift_r, shift_nxt_s;
  logic [7:0]        sum_r, sum_nxt_s;
  logic [ADDR_W-1:0] waddr_r, waddr_nxt_s;
  logic [31:0]       wdata_r, wdata_nxt_s;
  logic              rx_ready_r, we_r, cpu_hold_r, busy_r, done_r, err_r;
  logic              accept_s;
  logic [15:0]       len_in_s;
  logic [7:0]        word_inc_s;

  assign accept_s   = rx_valid && rx_state(state_r);
  assign len_in_s   = {rx_data, len_lo_r};
  assign word_inc_s = word_idx_r + 8'd1;

  // Next-state and datapath update for the frame parser
  always_comb begin
    state_nxt_s    = state_r;
    len_lo_nxt_s   = len_lo_r;
    len_nxt_s      = len_r;
    word_idx_nxt_s = word_idx_r;
    byte_idx_nxt_s = byte_idx_r;
    shift_nxt_s    = shift_r;
    waddr_nxt_s    = waddr_r;
    wdata_nxt_s    = wdata_r;
    if (accept_s) begin
      sum_nxt_s = csum_add(sum_r, rx_data);
    end else begin
      sum_nxt_s = sum_r;
    end

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt_s    = S_LEN_LO;
          word_idx_nxt_s = 8'd0;
          byte_idx_nxt_s = 2'd0;
          sum_nxt_s      = 8'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_lo_nxt_s = rx_data;
          state_nxt_s  = S_LEN_HI;
        end else begin
          state_nxt_s = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          len_nxt_s = len_in_s;
          if (len_in_s > DEPTH_W) begin
            state_nxt_s = S_ERR;
          end else if (len_in_s == 16'd0) begin
            state_nxt_s = S_CSUM;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = S_LEN_HI;
        end
      end
      S_DATA: begin
        // Bytes shift in from the top so the first byte lands in bits 7:0
        if (accept_s) begin
          shift_nxt_s    = {rx_data, shift_r[31:8]};
          byte_idx_nxt_s = byte_idx_r + 2'd1;
          if (byte_idx_r == 2'd3) begin
            state_nxt_s = S_WRITE;
            waddr_nxt_s = ADDR_W'({word_idx_r, 2'b00});
            wdata_nxt_s = {rx_data, shift_r[31:8]};
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_WRITE: begin
        word_idx_nxt_s = word_inc_s;
        if ({8'd0, word_inc_s} == len_r) begin
          state_nxt_s = S_CSUM;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          if (csum_add(sum_r, rx_data) == 8'd0) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_ERR;
          end
        end else begin
          state_nxt_s = S_CSUM;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      len_lo_r   <= 8'd0;
      len_r      <= 16'd0;
      word_idx_r <= 8'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 32'd0;
      sum_r      <= 8'd0;
      waddr_r    <= '0;
      wdata_r    <= 32'd0;
      rx_ready_r <= 1'b0;
      we_r       <= 1'b0;
      cpu_hold_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      len_lo_r   <= len_lo_nxt_s;
      len_r      <= len_nxt_s;
      word_idx_r <= word_idx_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      sum_r      <= sum_nxt_s;
      waddr_r    <= waddr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      rx_ready_r <= rx_state(state_nxt_s);
      we_r       <= (state_nxt_s == S_WRITE);
      cpu_hold_r <= busy_state(state_nxt_s) || (state_nxt_s == S_ERR);
      busy_r     <= busy_state(state_nxt_s);
      done_r     <= (state_nxt_s == S_DONE);
      err_r      <= (state_nxt_s == S_ERR);
    end
  end

  assign rx_ready = rx_ready_r;
  assign we       = we_r;
  assign waddr    = waddr_r;
  assign wdata    = wdata_r;
  assign cpu_hold = cpu_hold_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames checked
// against a frame-level model of expected writes and final status.
module tb_imem_loader;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 12;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset, start, rx_valid, rx_ready, we, cpu_hold, busy, done, err;
  logic [7:0] rx_data;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic prev_we = 1'b0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (we === 1'b1) begin
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
      check1("rx_ready_in_write", rx_ready, 1'b0);
      check1("we_single_cycle", prev_we, 1'b0);
    end
    prev_we <= we;
  end

  // Entered and left just after a falling edge; the byte is accepted on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check1("byte_accept_wait", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic bq_t make_frame(input int n, input bit good);
    bq_t f;
    logic [7:0] s;
    logic [7:0] c;
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
    end
    s = 8'd0;
    foreach (f[i]) s = s + f[i];
    c = 8'd0 - s;
    if (!good) c = c + 8'($urandom_range(1, 255));
    f.push_back(c);
    return f;
  endfunction

  task automatic run_frame(input bq_t f, input bit gaps, input int start_at, input string tag);
    int n, consumed;
    logic [7:0] sum;
    bit exp_done;
    int exp_addr[$];
    logic [31:0] exp_data[$];
    got_addr.delete();
    got_data.delete();
    n = int'({f[1], f[0]});
    if (n > DEPTH) begin
      consumed = 2;
      exp_done = 1'b0;
    end else begin
      consumed = 3 + 4 * n;
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(4 * i);
        exp_data.push_back({f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]});
      end
      sum = 8'd0;
      for (int i = 0; i < consumed; i++) sum = sum + f[i];
      exp_done = (sum == 8'd0);
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check1({tag, "/busy_after_start"}, busy, 1'b1);
    check1({tag, "/hold_after_start"}, cpu_hold, 1'b1);
    check1({tag, "/ready_after_start"}, rx_ready, 1'b1);
    check1({tag, "/done_cleared"}, done, 1'b0);
    check1({tag, "/err_cleared"}, err, 1'b0);

    for (int i = 0; i < consumed; i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(f[i], gaps);
      start = 1'b0;
    end

    check1({tag, "/done"}, done, exp_done);
    check1({tag, "/err"}, err, !exp_done);
    check1({tag, "/cpu_hold"}, cpu_hold, !exp_done);
    check1({tag, "/busy_end"}, busy, 1'b0);
    check1({tag, "/ready_end"}, rx_ready, 1'b0);
    check32({tag, "/write_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        check32({tag, "/waddr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
        check32({tag, "/wdata"}, got_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "/rx_ready"}, rx_ready, 1'b0);
    check1({tag, "/we"}, we, 1'b0);
    check32({tag, "/waddr"}, 32'(waddr), 32'd0);
    check32({tag, "/wdata"}, wdata, 32'd0);
    check1({tag, "/cpu_hold"}, cpu_hold, 1'b0);
    check1({tag, "/busy"}, busy, 1'b0);
    check1({tag, "/done"}, done, 1'b0);
    check1({tag, "/err"}, err, 1'b0);
  endtask

  initial begin
    bq_t f;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    f = '{8'h01, 8'h00, 8'h93, 8'h02, 8'h00, 8'h00, 8'h6A};
    run_frame(f, 1'b0, -1, "single_word");
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    run_frame(f, 1'b1, -1, "two_words_gaps");
    f = '{8'h01, 8'h00, 8'h93, 8'h02, 8'h00, 8'h00, 8'h6B};
    run_frame(f, 1'b0, -1, "bad_csum");
    repeat (3) @(negedge clk);
    check1("bad_csum/hold_level", cpu_hold, 1'b1);
    check1("bad_csum/err_level", err, 1'b1);
    f = '{8'h81, 8'h00};
    run_frame(f, 1'b0, -1, "oversize");
    f = '{8'h00, 8'h00, 8'h00};
    run_frame(f, 1'b1, -1, "zero_len");
    repeat (2) @(negedge clk);
    check1("zero_len/done_level", done, 1'b1);

    // Abort a session mid-payload with reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAB, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_reset");
    @(negedge clk);
    run_frame(make_frame(2, 1'b1), 1'b1, -1, "after_reset");

    run_frame(make_frame(3, 1'b1), 1'b1, 4, "start_while_busy");
    run_frame(make_frame(DEPTH, 1'b1), 1'b0, -1, "max_depth");
    run_frame(make_frame(DEPTH + 1, 1'b1), 1'b0, -1, "depth_plus_one");

    for (int k = 0; k < 24; k++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, 600)) : int'($urandom_range(0, 6));
      run_frame(make_frame(n, $urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 12)) - 6, "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
